// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmit line between NUM_REQ byte sources. A round-robin
//   arbiter accepts one byte at a time and serialises it as a start bit,
//   DATA_BITS data bits (LSB first) and STOP_BITS stop bits, each bit lasting
//   OVERSAMPLE ticks of the baud generator strobe.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   tick       one-clk-wide oversampling strobe
//   req_valid  per-requester byte-valid
//   req_data   requester i byte at [i*DATA_BITS +: DATA_BITS]
//   req_ready  one-hot accept strobe (only ever high in IDLE)
//   tx         serial line, idle high
//   busy       frame in progress
//   grant_id   index of the current/last granted requester
//   done       one-clk pulse once the stop bit(s) have completed
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         done
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned TW = $clog2(OVERSAMPLE*STOP_BITS) + 1;
  localparam int unsigned BW = $clog2(DATA_BITS) + 1;

  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(OVERSAMPLE*STOP_BITS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [GW:0]   NR_EXT    = (GW+1)'(NUM_REQ);
  localparam logic [GW-1:0] ID_LAST   = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state, state_n;
  logic [TW-1:0]          tick_cnt, tick_cnt_n;
  logic [BW-1:0]          bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic [GW-1:0]          ptr, ptr_n;
  logic [GW-1:0]          grant_n;
  logic                   tx_n;
  logic                   done_n;

  logic                   win_found;
  logic [GW-1:0]          win_idx;
  logic [GW:0]            cand;
  logic                   grant_ok;

  // Round-robin search starting at ptr; the candidate index is wrapped
  // explicitly so non-power-of-two NUM_REQ works.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (GW+1)'(k);
      if (cand >= NR_EXT) cand = cand - NR_EXT;
      if (!win_found && req_valid[cand[GW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[GW-1:0];
      end
    end
  end

  assign grant_ok = (state == IDLE) && !reset && win_found;

  always_comb begin
    req_ready = '0;
    if (grant_ok) req_ready[win_idx] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    ptr_n      = ptr;
    grant_n    = grant_id;
    tx_n       = tx;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (grant_ok) begin
          shreg_n    = req_data[win_idx*DATA_BITS +: DATA_BITS];
          grant_n    = win_idx;
          state_n    = START;
          tx_n       = 1'b0;
          tick_cnt_n = '0;
          bit_cnt_n  = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt == BIT_LAST) begin
            state_n    = DATA;
            tick_cnt_n = '0;
            bit_cnt_n  = '0;
            tx_n       = shreg[0];
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_cnt_n = '0;
            if (bit_cnt == DATA_LAST) begin
              state_n   = STOP;
              bit_cnt_n = '0;
              tx_n      = 1'b1;
            end else begin
              // tx is registered, so it takes the bit that becomes bit 0
              shreg_n   = shreg >> 1;
              bit_cnt_n = bit_cnt + 1'b1;
              tx_n      = shreg[1];
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (tick) begin
          if (tick_cnt == STOP_LAST) begin
            state_n    = IDLE;
            tick_cnt_n = '0;
            bit_cnt_n  = '0;
            done_n     = 1'b1;
            ptr_n      = (grant_id == ID_LAST) ? '0 : grant_id + 1'b1;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      ptr      <= '0;
      grant_id <= '0;
      tx       <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      ptr      <= ptr_n;
      grant_id <= grant_n;
      tx       <= tx_n;
      done     <= done_n;
    end
  end

endmodule
